// File: rtl/top_xp_fifo.sv
// Single-clock synchronous FIFO with registered dequeue output, status decodes and sticky error flags.
// Define TOP_XP_ASSERT_EN to elaborate the embedded SVA invariant checks and cover points.
module top_xp_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     enq,
    input  logic                     deq,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            dout,
    output logic                     dout_valid,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          dout_valid_q, dout_valid_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          do_enq, do_deq;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // A pop frees a slot in the same cycle, so a full queue may still accept a push.
    assign do_deq = deq & ~empty;
    assign do_enq = enq & (~full | do_deq);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        if (do_enq) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_deq) begin
            rd_ptr_d     = rd_ptr_q + AW'(1);
            dout_d       = mem_q[rd_ptr_q];
            dout_valid_d = 1'b1;
        end
        if (do_enq && !do_deq) begin
            count_d = count_q + CW'(1);
        end else if (!do_enq && do_deq) begin
            count_d = count_q - CW'(1);
        end
        if (enq && !do_enq) begin
            overflow_d = 1'b1;
        end
        if (deq && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage is intentionally left unreset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (!rstn && do_enq) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

`ifdef TOP_XP_ASSERT_EN
    a_count_bound: assert property (@(posedge clk) disable iff (rstn)
        count_q <= CW'(DEPTH));
    a_full_not_empty: assert property (@(posedge clk) disable iff (rstn)
        full |-> !empty);
    a_count_ptrs: assert property (@(posedge clk) disable iff (rstn)
        full ? (wr_ptr_q == rd_ptr_q) : (count_q == {1'b0, AW'(wr_ptr_q - rd_ptr_q)}));
    a_count_inc: assert property (@(posedge clk) disable iff (rstn)
        (do_enq && !do_deq) |=> (count_q == $past(count_q) + CW'(1)));
    a_deq_valid: assert property (@(posedge clk) disable iff (rstn)
        do_deq |=> dout_valid_q);
    a_overflow_sticky: assert property (@(posedge clk) disable iff (rstn)
        overflow_q |=> overflow_q);
    a_underflow_sticky: assert property (@(posedge clk) disable iff (rstn)
        underflow_q |=> underflow_q);
    c_full: cover property (@(posedge clk) disable iff (rstn) full);
    c_empty_after_full: cover property (@(posedge clk) disable iff (rstn)
        full ##[1:$] empty);
    c_wr_wrap: cover property (@(posedge clk) disable iff (rstn)
        (do_enq && wr_ptr_q == AW'(DEPTH - 1)));
`endif

endmodule

// File: tb/tb_top_xp_fifo.sv
// Directed plus randomized bench for top_xp_fifo against a queue-based reference model.
module tb_top_xp_fifo;
  localparam int DEPTH = 16;
  localparam int DW    = 32;

  logic          clk;
  logic          rstn;
  logic          enq;
  logic          deq;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          full;
  logic          empty;
  logic [4:0]    count;
  logic          overflow;
  logic          underflow;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_dout;
  logic          m_dv;
  logic          m_ov;
  logic          m_un;

  top_xp_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .enq        (enq),
    .deq        (deq),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("count", 32'(count), 32'(exp_q.size()));
    chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(exp_q.size() == 0));
    chk("dout_valid", 32'(dout_valid), 32'(m_dv));
    chk("dout", dout, m_dout);
    chk("overflow", 32'(overflow), 32'(m_ov));
    chk("underflow", 32'(underflow), 32'(m_un));
  endtask

  // Model: a pop comes out of the pre-edge contents; a push lands after it.
  task automatic model(input logic r, input logic e, input logic d, input logic [DW-1:0] w);
    bit did_deq;
    bit did_enq;
    if (r) begin
      exp_q.delete();
      m_dout = '0;
      m_dv   = 1'b0;
      m_ov   = 1'b0;
      m_un   = 1'b0;
    end else begin
      did_deq = d && (exp_q.size() > 0);
      did_enq = e && ((exp_q.size() < DEPTH) || did_deq);
      if (d && !did_deq) m_un = 1'b1;
      if (e && !did_enq) m_ov = 1'b1;
      m_dv = did_deq;
      if (did_deq) m_dout = exp_q.pop_front();
      if (did_enq) exp_q.push_back(w);
    end
  endtask

  // driver: inputs change on the falling edge, outputs checked 1 time unit after the rising edge
  task automatic step(input logic r, input logic e, input logic d, input logic [DW-1:0] w);
    rstn = r;
    enq  = e;
    deq  = d;
    din  = w;
    model(r, e, d, w);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic push(input logic [DW-1:0] w);
    step(1'b0, 1'b1, 1'b0, w);
  endtask

  task automatic pop();
    step(1'b0, 1'b0, 1'b1, $urandom);
  endtask

  initial begin
    rstn = 1'b1;
    enq  = 1'b0;
    deq  = 1'b0;
    din  = '0;
    @(negedge clk);

    // reset for two cycles
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 32'hdead_beef);

    // ten words in, ten out in order
    for (int i = 0; i < 10; i++) push(32'h1000_0000 + 32'(i));
    for (int i = 0; i < 10; i++) pop();
    step(1'b0, 1'b0, 1'b0, '0);

    // fill past capacity, then drain
    for (int i = 0; i < 17; i++) push(32'h2000_0000 + 32'(i));
    for (int i = 0; i < 16; i++) pop();

    // dequeue while empty: dout holds, underflow sets
    pop();
    pop();

    // simultaneous enq+deq at full, at 5 and at 0
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 16; i++) push($urandom);
    step(1'b0, 1'b1, 1'b1, 32'h3000_0016);
    step(1'b0, 1'b1, 1'b1, 32'h3000_0017);
    for (int i = 0; i < 11; i++) pop();
    step(1'b0, 1'b1, 1'b1, 32'h3000_0005);
    for (int i = 0; i < 5; i++) pop();
    step(1'b0, 1'b1, 1'b1, 32'h3000_0000);
    pop();

    // reset mid-stream at count 7
    for (int i = 0; i < 7; i++) push($urandom);
    step(1'b1, 1'b1, 1'b1, 32'h4444_4444);
    push(32'h5555_aaaa);
    pop();

    // randomized phases with shifting enq/deq bias
    for (int p = 0; p < 6; p++) begin
      int enq_pct;
      int deq_pct;
      enq_pct = (p % 3 == 0) ? 85 : ((p % 3 == 1) ? 20 : 55);
      deq_pct = (p % 3 == 0) ? 25 : ((p % 3 == 1) ? 85 : 55);
      for (int c = 0; c < 80; c++) begin
        step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) < enq_pct) ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) < deq_pct) ? 1'b1 : 1'b0,
             $urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/top_xp_fifo.md
# top_xp_fifo

Single-clock, synchronous 32-bit FIFO queue with enqueue/dequeue strobes, status flags and sticky error flags. It is the top-level block used as the formal/assertion verification target. Producers push words with `enq`/`din`; consumers pop with `deq` and receive the word on a registered output one cycle later. An optional embedded assertion set checks the block's own invariants.

## Interface
- `DEPTH`, 16, number of 32-bit entries; power of two, ≥ 2.
- `DW`, 32, data width.
- `clk`  in  1  clock; all logic on the rising edge.
- `rstn`  in  1  reset: synchronous, active-high (asserted = 1, despite the name).
- `enq`  in  1  enqueue strobe; samples `din` when accepted.
- `deq`  in  1  dequeue strobe.
- `din`  in  DW  enqueue data.
- `dout`  out  DW  registered dequeued word.
- `dout_valid`  out  1  one-cycle pulse: `dout` updated this cycle.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky: an enqueue was dropped.
- `underflow`  out  1  sticky: a dequeue hit an empty queue.

## Operation
- Storage: DEPTH×DW register array.
- Pointers: `wr_ptr` and `rd_ptr`, $clog2(DEPTH) bits each. They wrap modulo DEPTH naturally.
- Accept rules, evaluated on the pre-edge state:
  - `do_deq = deq & !empty`.
  - `do_enq = enq & (!full | do_deq)`.
- On `do_enq`: `mem[wr_ptr] <= din` and `wr_ptr` increments.
- On `do_deq`: `dout <= mem[rd_ptr]`, `rd_ptr` increments, and `dout_valid <= 1`. Otherwise `dout_valid <= 0` and `dout` holds its value.
- `count` changes by +1 (enq only), −1 (deq only), or 0 (both or neither).
- `enq` while full without `do_deq`: the word is dropped, `overflow <= 1`, and no state changes.
- `deq` while empty: ignored, `underflow <= 1`, and `dout` holds. This applies even when `enq` is also asserted; the enqueue still proceeds.
- Simultaneous enq+deq when empty: only the enqueue occurs. There is no bypass path.
- Simultaneous enq+deq when full: both occur and `count` stays at DEPTH.
- `full` and `empty` are combinational decodes of the registered `count`.
- Sticky flags clear only on reset.

## Timing
- Reset (`rstn`=1 at a rising edge) sets:
  - pointers and `count` to 0;
  - `empty`=1, `full`=0;
  - `dout`=0, `dout_valid`=0;
  - `overflow`=0, `underflow`=0.
- Memory contents are not reset.
- Reset has priority over `enq`/`deq` in the same cycle. Reset mid-operation discards all queued data.
- A word enqueued at edge N can be dequeued by `deq` sampled at edge N+1. It appears on `dout` with `dout_valid`=1 after that edge.
- Dequeue latency: 1 cycle from the `deq` sample to `dout`.
- Throughput: one enqueue and one dequeue per cycle.

## Configuration
- `TOP_XP_ASSERT_EN` defined: the module compiles embedded concurrent SVA, all disabled during reset. The assertions are:
  - `count` ≤ DEPTH;
  - `full` implies !`empty`;
  - `count` equals (wr_ptr − rd_ptr) mod DEPTH, or DEPTH when full;
  - `do_enq` and !`do_deq` implies `count` +1 at the next cycle;
  - `do_deq` implies `dout_valid` at the next cycle;
  - `overflow` and `underflow` never fall without reset;
  - cover properties for reaching full, reaching empty after full, and pointer wrap.
- Undefined: no assertion or cover code is elaborated; functional behaviour is identical.

## Test plan
- Reset for 2 cycles → `empty`=1, `full`=0, `count`=0, `dout`=0, `dout_valid`=0, flags 0.
- Enqueue 10 words (0x1000_0000+i), then dequeue 10 → `dout` returns them in order, one per cycle, each with a `dout_valid` pulse; `count` ends at 0 and `empty`=1.
- Enqueue 16 words, then a 17th → `full`=1, `count`=16, `overflow`=1. A later full drain yields exactly the first 16 words.
- `deq` while empty → `underflow`=1, `dout` unchanged, `dout_valid`=0.
- Simultaneous enq+deq at count=16 and at count=5 → `count` unchanged and order preserved. At count=0 → `count` becomes 1 and `dout_valid`=0.
- Assert reset mid-stream at count=7 → `count`=0 and `empty`=1 next cycle; the next enqueue/dequeue returns the new word.
